adder_operand_sequencer: RTL
============================

# adder_operand_sequencer

Valid/ready sequencing stage wrapped around the 16-bit combinational carry-skip adder. It accepts an operand set, registers it onto the adder inputs and holds it stable for a fixed settle window. It then captures the adder's sum and carry-out with status flags and presents the result downstream under valid/ready backpressure. The adder is instantiated beside this block, not inside it: this block drives `add_*` and samples `add_sum` / `add_cout`.

## Interface
- `WIDTH`, 16 — operand and sum width; must match the adder.
- `SETTLE_CYCLES`, 2 — cycles the operands are held on the adder before capture; legal range 1..15.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `in_valid`  in  1  — upstream operand set valid.
- `in_ready`  out  1  — this block accepts operands this cycle.
- `in_a`, `in_b`  in  WIDTH  — operands.
- `in_cin`  in  1  — carry-in.
- `add_a`, `add_b`  out  WIDTH  — registered operands to the adder.
- `add_cin`  out  1  — registered carry-in to the adder.
- `add_sum`  in  WIDTH  — adder sum.
- `add_cout`  in  1  — adder carry-out.
- `out_valid`  out  1  — result valid.
- `out_ready`  in  1  — downstream accepts the result.
- `out_sum`  out  WIDTH  — captured sum.
- `out_cout`  out  1  — captured carry-out.
- `out_zero`  out  1  — `out_sum == 0`.
- `out_ovf`  out  1  — two's-complement overflow.

## Operation
- FSM states: IDLE, SETTLE, DONE.
- `in_ready = (state==IDLE) || (state==DONE && out_ready)`. This output is combinational from state and `out_ready`.
- Accept condition: `in_valid && in_ready` at an edge.
  - Load `add_a`, `add_b`, `add_cin` from the inputs.
  - Load `cnt = SETTLE_CYCLES-1`.
  - Go to SETTLE.
- SETTLE:
  - If `cnt != 0`, decrement.
  - If `cnt == 0`, capture `out_sum <= add_sum`, `out_cout <= add_cout`, and both flags, set `out_valid`, and go to DONE.
- DONE:
  - `out_valid` and all `out_*` values are held stable until `out_ready`.
  - On `out_ready` without a new accept, clear `out_valid` and go to IDLE.
  - On `out_ready` with a simultaneous accept, load the new operands, clear `out_valid`, and go to SETTLE.
- `add_*` registers change only on accept, so operands stay stable through SETTLE and DONE.
- Flag and width rules:
  - `out_zero = ~|add_sum` at capture.
  - `out_ovf = (add_a[W-1]==add_b[W-1]) && (add_sum[W-1]!=add_a[W-1])`. `add_cin` does not enter the formula.
  - Sum wraps modulo 2^WIDTH; the carry appears only on `out_cout`.
- `in_valid` while `in_ready` is low is ignored: no state change and no data captured. Upstream must hold its data.
- Reset, asynchronous and valid mid-operation:
  - State returns to IDLE and `cnt` to 0.
  - All `add_*` and `out_*` registers reset to 0, including `out_valid`.
  - Any in-flight operation is discarded.
  - `in_ready` reads 1 after reset.

## Timing
- Latency: accept at edge k, so `out_valid` rises after edge k+`SETTLE_CYCLES`.
- The adder sees new operands for exactly `SETTLE_CYCLES` full cycles before capture.
- Throughput with `out_ready` held high: one result per `SETTLE_CYCLES+1` cycles, using the back-to-back accept in DONE.
- `out_*` are registered. `in_ready` depends combinationally on `out_ready`, so downstream must not derive `out_ready` from `in_ready`.
- `SETTLE_CYCLES` outside 1..15 is an elaboration error.

## Structure
- Package `adder_seq_pkg` holds:
  - the state enum (IDLE, SETTLE, DONE);
  - the default `WIDTH` constant;
  - the 4-bit settle-counter width constant.
- One sub-module, `add_status_flags`: combinational zero/overflow from `add_a`, `add_b`, `add_sum`, parameterised by `WIDTH`.
- The FSM, counter and registers stay in the top module.

## Test plan
- Reset with `SETTLE_CYCLES=2`: all outputs 0 and `in_ready=1`. Apply `0x0005 + 0x0005`, cin=1 → `out_valid` 2 edges after accept, `out_sum=0x000B`, cout=0, zero=0, ovf=0.
- `0xFFFF + 0x0000`, cin=1 → `out_sum=0x0000`, cout=1, zero=1, ovf=0. Then `0x7FFF + 0x0001`, cin=0 → `0x8000`, cout=0, ovf=1.
- Hold `out_ready=0` for 5 cycles in DONE while pulsing `in_valid` with new data → `in_ready=0`; `out_*` and `add_*` unchanged; the new data is not taken.
- Keep `in_valid` and `out_ready` high and stream 4 operand sets → one result every 3 cycles, in order, with `in_ready` high in each DONE cycle.
- Assert `rst_n` low in mid-SETTLE, asynchronous and not on an edge → outputs 0 immediately; after release, the next operand set produces the correct, uncorrupted result.
- Repeat the first case with `SETTLE_CYCLES=1` and with 15 → latency is 1 and 15 edges respectively.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the adder operand sequencer.
package adder_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Settle counter width, enough for the largest legal settle window of 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } seq_state_e;

endpackage

// File: rtl/add_status_flags.sv
// Combinational status flags derived from the adder operands and sum.
module add_status_flags
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  output logic             zero_o,
  output logic             ovf_o
);

  // Zero when every sum bit is clear; overflow when like-signed operands
  // give a sum of the opposite sign. The carry-in never enters the rule.
  always_comb begin
    zero_o = ~|sum_i;
    ovf_o  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_i[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Valid/ready sequencer that holds operands on an external adder for a
// fixed settle window, then captures the sum with status flags.
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic             in_cin_i,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  output logic             add_cin_o,
  input  logic [WIDTH-1:0] add_sum_i,
  input  logic             add_cout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_cout_o,
  output logic             out_zero_o,
  output logic             out_ovf_o
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("adder_operand_sequencer: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_b_q;
  logic             add_cin_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_zero_q;
  logic             out_ovf_q;
  logic             flag_zero;
  logic             flag_ovf;
  logic             accept;

  add_status_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .a_i    (add_a_q),
    .b_i    (add_b_q),
    .sum_i  (add_sum_i),
    .zero_o (flag_zero),
    .ovf_o  (flag_ovf)
  );

  // Ready in IDLE, or in DONE when the held result leaves this same cycle.
  always_comb begin
    in_ready_o = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    accept     = in_valid_i && in_ready_o;
    cnt_d      = cnt_q - CNT_W'(1);
  end

  // Sequencing FSM: load operands on accept, count out the settle window,
  // capture the adder result, then hold it until downstream takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            add_a_q   <= in_a_i;
            add_b_q   <= in_b_i;
            add_cin_q <= in_cin_i;
            cnt_q     <= CNT_LOAD;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_d;
          end else begin
            out_sum_q   <= add_sum_i;
            out_cout_q  <= add_cout_i;
            out_zero_q  <= flag_zero;
            out_ovf_q   <= flag_ovf;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              add_a_q   <= in_a_i;
              add_b_q   <= in_b_i;
              add_cin_q <= in_cin_i;
              cnt_q     <= CNT_LOAD;
              state_q   <= SETTLE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Every downstream-facing output comes straight from a register.
  always_comb begin
    add_a_o     = add_a_q;
    add_b_o     = add_b_q;
    add_cin_o   = add_cin_q;
    out_valid_o = out_valid_q;
    out_sum_o   = out_sum_q;
    out_cout_o  = out_cout_q;
    out_zero_o  = out_zero_q;
    out_ovf_o   = out_ovf_q;
  end

endmodule
